// File: rtl/pkt_analyser.sv
// Header-driven packet router front end: parses {dsap, ssap, len}, requests the
// destination port from an arbiter, then streams len payload beats or drops the frame.
module pkt_analyser #(
  parameter int NPORT = 4,
  parameter int DW    = 8,
  parameter int CW    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [3*DW-1:0]   in_data,
  output logic              in_ready,
  output logic [NPORT-1:0]  req_out,
  input  logic              grant_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     data_out,
  output logic [DW-1:0]     src_out,
  output logic              last_out,
  output logic              err_drop,
  output logic [CW-1:0]     drop_cnt
);

  localparam int PW = $clog2(NPORT);
  localparam logic [NPORT-1:0] PORT0   = {{(NPORT-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0]    BEAT1   = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, REQ, TRANS, DROP} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     ssap_q, ssap_d;
  logic [DW-1:0]     cnt_q, cnt_d;
  logic [NPORT-1:0]  req_q, req_d;
  logic              err_q, err_d;
  logic [CW-1:0]     drop_q, drop_d;

  logic [DW-1:0]     hdr_dsap, hdr_ssap, hdr_len;
  logic              hdr_ok;

  assign hdr_dsap = in_data[3*DW-1:2*DW];
  assign hdr_ssap = in_data[2*DW-1:DW];
  assign hdr_len  = in_data[DW-1:0];
  // Only the low log2(NPORT) dsap bits may be set; an empty frame is never routed.
  assign hdr_ok   = ((hdr_dsap >> PW) == {DW{1'b0}}) && (hdr_len != {DW{1'b0}});

  // Payload path is a zero-latency pass-through while TRANS owns the port.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      REQ:     in_ready = 1'b0;
      TRANS: begin
        in_ready  = out_ready;
        out_valid = in_valid;
      end
      DROP:    in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
    if (reset) begin
      in_ready = 1'b0;
    end
  end

  assign data_out = in_data[DW-1:0];
  assign src_out  = ssap_q;
  assign last_out = out_valid && (cnt_q == BEAT1);
  assign req_out  = req_q;
  assign err_drop = err_q;
  assign drop_cnt = drop_q;

  // Next-state logic for the frame FSM and its registered side outputs.
  always_comb begin
    state_d = state_q;
    ssap_d  = ssap_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    err_d   = 1'b0;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ssap_d = hdr_ssap;
          cnt_d  = hdr_len;
          if (hdr_ok) begin
            state_d = REQ;
            req_d   = PORT0 << hdr_dsap[PW-1:0];
          end else begin
            err_d   = 1'b1;
            drop_d  = (drop_q == {CW{1'b1}}) ? drop_q : drop_q + CNT_ONE;
            state_d = (hdr_len == {DW{1'b0}}) ? IDLE : DROP;
          end
        end
      end
      REQ: begin
        if (grant_in) begin
          state_d = TRANS;
        end
      end
      TRANS: begin
        if (in_valid && out_ready) begin
          cnt_d = cnt_q - BEAT1;
          if (cnt_q == BEAT1) begin
            state_d = IDLE;
            req_d   = {NPORT{1'b0}};
          end
        end
      end
      DROP: begin
        if (in_valid) begin
          cnt_d = cnt_q - BEAT1;
          if (cnt_q == BEAT1) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = {NPORT{1'b0}};
      end
    endcase
  end

  // State registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ssap_q  <= {DW{1'b0}};
      cnt_q   <= {DW{1'b0}};
      req_q   <= {NPORT{1'b0}};
      err_q   <= 1'b0;
      drop_q  <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      ssap_q  <= ssap_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_pkt_analyser.sv
// Scoreboard bench for pkt_analyser: stimulus pushes expected beats and drop
// counts into queues, a negedge monitor pops and compares them.
module tb_pkt_analyser;

  localparam int NPORT = 4;
  localparam int DW    = 8;
  localparam int CW    = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [3*DW-1:0]   in_data = '0;
  logic              in_ready;
  logic [NPORT-1:0]  req_out;
  logic              grant_in = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     data_out, src_out;
  logic              last_out, err_drop;
  logic [CW-1:0]     drop_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] s;
    logic       l;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] drop_exp_q[$];

  pkt_analyser #(.NPORT(NPORT), .DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .req_out(req_out), .grant_in(grant_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .src_out(src_out), .last_out(last_out), .err_drop(err_drop),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every transfer and every drop pulse must match the head of its queue.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got data 0x%0h, expected no beat", data_out);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", 32'(data_out), 32'(e.d));
          chk("beat_src", 32'(src_out), 32'(e.s));
          chk("beat_last", 32'(last_out), 32'(e.l));
        end
      end
      if (err_drop) begin
        if (drop_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL drop_unexpected: got err_drop with drop_cnt 0x%0h, expected none", drop_cnt);
        end else begin
          chk("drop_cnt_at_pulse", 32'(drop_cnt), 32'(drop_exp_q.pop_front()));
        end
      end
    end
  end

  task automatic send_header(input logic [7:0] d, input logic [7:0] s, input logic [7:0] l);
    in_valid = 1'b1;
    in_data  = {d, s, l};
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic grant_after(input int delay, input logic [3:0] req_exp);
    for (int i = 0; i < delay; i++) begin
      in_valid = 1'b1;
      in_data  = 24'hFFFFEE;
      @(negedge clk);
      chk("req_held", 32'(req_out), 32'(req_exp));
      chk("req_in_ready", 32'(in_ready), 32'h0);
      chk("req_out_valid", 32'(out_valid), 32'h0);
      tick();
    end
    in_valid = 1'b0;
    grant_in = 1'b1;
    @(negedge clk);
    chk("req_at_grant", 32'(req_out), 32'(req_exp));
    tick();
    grant_in = 1'b0;
  endtask

  task automatic run_payload(input logic [7:0] base, input logic [7:0] src, input int n,
                             input logic [15:0] rdy_pat, input int pat_len);
    int   idx;
    int   cyc;
    logic r;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 64) begin
      r = (cyc < pat_len) ? rdy_pat[cyc] : 1'b1;
      in_valid  = 1'b1;
      in_data   = {16'h0000, 8'(base + 8'(idx))};
      out_ready = r;
      if (r) exp_q.push_back({8'(base + 8'(idx)), src, (idx == n - 1)});
      @(negedge clk);
      chk("trans_in_ready", 32'(in_ready), 32'(r));
      chk("trans_out_valid", 32'(out_valid), 32'h1);
      tick();
      if (r) idx++;
      cyc++;
    end
    if (idx < n) begin
      chk("payload_timeout", 32'(idx), 32'(n));
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_frame_req", 32'(req_out), 32'h0);
    chk("post_frame_ready", 32'(in_ready), 32'h1);
    tick();
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_req", 32'(req_out), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_last", 32'(last_out), 32'h0);
    chk("rst_err", 32'(err_drop), 32'h0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1 chk("post_rst_ready", 32'(in_ready), 32'h1);
    tick();

    // Immediate grant, three beats with continuous out_ready.
    send_header(8'h02, 8'h11, 8'h03);
    grant_after(0, 4'b0100);
    run_payload(8'hA0, 8'h11, 3, 16'hFFFF, 16);

    // Grant delayed five cycles.
    send_header(8'h03, 8'h22, 8'h02);
    grant_after(5, 4'b1000);
    run_payload(8'hB0, 8'h22, 2, 16'hFFFF, 16);

    // Back-pressure pattern 1,0,0,1,1 then ready.
    send_header(8'h01, 8'h33, 8'h05);
    grant_after(0, 4'b0010);
    run_payload(8'hC0, 8'h33, 5, 16'h0019, 5);

    // Out-of-range dsap: frame of two beats swallowed.
    drop_exp_q.push_back(16'h0001);
    send_header(8'h05, 8'h44, 8'h02);
    for (int i = 0; i < 2; i++) begin
      in_valid  = 1'b1;
      in_data   = {16'h0000, 8'(8'hD0 + 8'(i))};
      out_ready = 1'b1;
      @(negedge clk);
      chk("drop_err_pulse", 32'(err_drop), (i == 0) ? 32'h1 : 32'h0);
      chk("drop_cnt_1", 32'(drop_cnt), 32'h1);
      chk("drop_out_valid", 32'(out_valid), 32'h0);
      chk("drop_req", 32'(req_out), 32'h0);
      chk("drop_in_ready", 32'(in_ready), 32'h1);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("drop_done_err", 32'(err_drop), 32'h0);
    chk("drop_done_ready", 32'(in_ready), 32'h1);
    tick();

    // Zero-length header: counted as a drop, stays in IDLE.
    drop_exp_q.push_back(16'h0002);
    send_header(8'h00, 8'h44, 8'h00);
    @(negedge clk);
    chk("len0_err", 32'(err_drop), 32'h1);
    chk("len0_drop_cnt", 32'(drop_cnt), 32'h2);
    chk("len0_ready", 32'(in_ready), 32'h1);
    chk("len0_req", 32'(req_out), 32'h0);
    tick();

    // Asynchronous reset after one of four beats.
    send_header(8'h00, 8'h66, 8'h04);
    grant_after(0, 4'b0001);
    in_valid  = 1'b1;
    in_data   = 24'h0000E0;
    out_ready = 1'b1;
    exp_q.push_back({8'hE0, 8'h66, 1'b0});
    @(negedge clk);
    tick();
    in_data = 24'h0000E1;
    #1 reset = 1'b1;
    #1;
    chk("async_rst_req", 32'(req_out), 32'h0);
    chk("async_rst_out_valid", 32'(out_valid), 32'h0);
    chk("async_rst_ready", 32'(in_ready), 32'h0);
    repeat (2) @(posedge clk);
    #3;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rerst_ready", 32'(in_ready), 32'h1);
    chk("rerst_drop_cnt", 32'(drop_cnt), 32'h0);
    tick();
    send_header(8'h01, 8'h77, 8'h01);
    grant_after(0, 4'b0010);
    run_payload(8'hF0, 8'h77, 1, 16'hFFFF, 16);

    // Saturation: 65535 zero-length drops reach all-ones, one more must hold it.
    for (int i = 0; i < 65536; i++) begin
      in_valid = 1'b1;
      in_data  = (i == 65535) ? 24'h080000 : 24'h000000;
      drop_exp_q.push_back((i < 65535) ? 16'(i + 1) : 16'hFFFF);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("sat_drop_cnt", 32'(drop_cnt), 32'hFFFF);
    chk("sat_err_pulse", 32'(err_drop), 32'h1);
    tick();
    @(negedge clk);
    chk("sat_err_clear", 32'(err_drop), 32'h0);
    chk("sat_drop_hold", 32'(drop_cnt), 32'hFFFF);
    tick();

    chk("beats_outstanding", 32'(exp_q.size()), 32'h0);
    chk("drops_outstanding", 32'(drop_exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pkt_analyser.md
PKT_ANALYSER -- requirements
Module: pkt_analyser

Interface
REQ-001 Parameter NPORT, default 4, SHALL set the number of destination ports; power of two, 2..16.
REQ-002 Parameter DW, default 8, SHALL set the width of the dsap, ssap, len and payload fields.
REQ-003 Parameter CW, default 16, SHALL set the drop-counter width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 in_valid  input  1  SHALL mark in_data as valid.
REQ-007 in_data  input  3*DW  SHALL carry the header {dsap, ssap, len} or a payload beat in in_data[DW-1:0].
REQ-008 in_ready  output  1  SHALL accept in_data when it is high in the same cycle as in_valid.
REQ-009 req_out  output  NPORT  SHALL be the one-hot destination request to the arbiter.
REQ-010 grant_in  input  1  SHALL be the arbiter grant for the current req_out.
REQ-011 out_valid, out_ready  output, input  1 each  SHALL form the payload output handshake.
REQ-012 data_out  output  DW  SHALL carry the payload beat.
REQ-013 src_out  output  DW  SHALL carry the latched ssap.
REQ-014 last_out  output  1  SHALL mark the final payload beat.
REQ-015 err_drop  output  1  SHALL be a one-cycle pulse when a frame is dropped.
REQ-016 drop_cnt  output  CW  SHALL count dropped frames.

Function
REQ-017 The FSM SHALL have four states: IDLE, REQ, TRANS and DROP.
REQ-018 IDLE SHALL behave as follows:
- in_ready = 1.
- A header is accepted on in_valid & in_ready.
- dsap, ssap and len are latched, and the beat counter is set to len.
REQ-019 A header is valid when dsap[DW-1:log2(NPORT)] == 0 and len != 0; a valid header SHALL move the FSM IDLE->REQ.
REQ-020 An invalid header SHALL cause the following:
- err_drop pulses in the cycle after acceptance.
- drop_cnt increments, saturating at all-ones.
- len == 0 goes IDLE->IDLE; otherwise the FSM goes IDLE->DROP.
REQ-021 In REQ and TRANS, req_out SHALL equal 1 << dsap[log2(NPORT)-1:0], registered; it asserts the cycle after header acceptance, and req_out = 0 in IDLE and DROP.
REQ-022 REQ SHALL behave as follows:
- in_ready = 0 and out_valid = 0.
- grant_in high at a clock edge moves the FSM REQ->TRANS.
- req_out is held stable until grant_in is sampled high.
REQ-023 TRANS SHALL pass beats through combinationally, with zero latency:
- in_ready = out_ready.
- out_valid = in_valid.
- data_out = in_data[DW-1:0].
- src_out = latched ssap.
REQ-024 Each TRANS transfer (in_valid & out_ready) SHALL decrement the beat counter; last_out = 1 exactly when the counter == 1 and out_valid = 1.
REQ-025 The transfer that has last_out = 1 SHALL move the FSM TRANS->IDLE; req_out SHALL be 0 on the following cycle, and a new header may be accepted from that cycle.
REQ-026 DROP SHALL set in_ready = 1 and out_valid = 0, decrement the counter on every accepted beat, and go DROP->IDLE on the beat where the counter == 1.
REQ-027 grant_in outside REQ SHALL be ignored; grant_in deassertion during TRANS SHALL NOT stall or abort the frame.
REQ-028 Beat counting SHALL use DW-bit unsigned arithmetic; the maximum frame is 2^DW-1 payload beats, and len is never wrapped.
REQ-029 data_out, src_out and last_out SHALL be don't-care when out_valid = 0; the bench SHALL check them only when out_valid = 1.

Reset
REQ-030 On reset assertion, regardless of the clock, the block SHALL immediately set:
- state = IDLE.
- req_out = 0.
- out_valid = 0, last_out = 0, err_drop = 0.
- drop_cnt = 0.
- Latched dsap, ssap, len and the beat counter = 0.
REQ-031 in_ready SHALL be 0 while reset is high and 1 from the first cycle after deassertion.
REQ-032 Reset asserted mid-frame (in REQ, TRANS or DROP) SHALL abandon the frame with no further output beats; the remainder of that frame is not parsed.

Verification (NPORT=4, DW=8)
REQ-033 Header {dsap 0x02, ssap 0x11, len 3}, immediate grant, payload 0xA0, 0xA1, 0xA2 with out_ready = 1 -> req_out = 4'b0100 from T+1; three out beats with src_out = 0x11; last_out on 0xA2; req_out = 0 after.
REQ-034 Header dsap 0x03, grant delayed 5 cycles -> req_out = 4'b1000 held stable for 5 cycles, in_ready = 0 and out_valid = 0 throughout, then the frame forwards.
REQ-035 TRANS with out_ready toggling 1,0,0,1,1 -> in_ready mirrors out_ready; no beat lost or duplicated; the counter decrements only on transfers.
REQ-036 Header dsap 0x05, len 2 -> err_drop pulses once, drop_cnt = 1, 2 beats consumed with out_valid = 0, req_out stays 0; header len 0 -> drop_cnt = 2 and the FSM stays in IDLE.
REQ-037 Reset asserted asynchronously mid-TRANS after 1 of 4 beats -> req_out and out_valid = 0 without a clock edge; after release, a new header is accepted normally.
REQ-038 Force drop_cnt to 0xFFFF, then send an invalid header -> drop_cnt stays 0xFFFF and err_drop still pulses.
